flash_adc_seq_decoder: RTL

Parametrised successor to the 3-bit flash-ADC thermometer decoder. It sequences the sample/settle/capture cycle of a (2^NBITS-1)-comparator flash ADC and bubble-corrects the thermometer code. It averages 2^AVG_LOG2 conversions and presents the result on a valid/ready output port. It sits between the comparator bank (analog macro driven by samp) and the digital consumer (wishbone/logic-analyser side).

---
 rtl/flash_adc_seq_decoder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/flash_adc_seq_decoder.sv
// Flash-ADC sequencer and thermometer decoder.
// The block drives the sample/settle/capture cycle of a (2^NBITS-1)-comparator
// flash ADC. It bubble-corrects each captured thermometer code with a
// three-input majority vote and averages 2^AVG_LOG2 conversions. Each averaged
// result is presented on a valid/ready port.
module flash_adc_seq_decoder #(
  parameter int NBITS         = 3,
  parameter int AVG_LOG2      = 2,
  parameter int SAMP_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    start,
  input  logic [(2**NBITS)-2:0]   comp,
  output logic                    samp,
  output logic                    busy,
  output logic [NBITS-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    eoc,
  output logic                    bubble_err
);

  // Comparator count, accumulator width and conversion-counter width.
  // The accumulator holds at most M * 2^AVG_LOG2, so it cannot overflow.
  localparam int M      = (2**NBITS) - 1;
  localparam int ACC_W  = NBITS + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int PH_MAX = (SAMP_CYCLES > SETTLE_CYCLES) ? SAMP_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [CNT_W-1:0] LAST_CONV   = CNT_W'((2**AVG_LOG2) - 1);
  localparam logic [PH_W-1:0]  SAMP_LAST   = PH_W'(SAMP_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  // Majority of three bits.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Bubble-corrected code of a thermometer word.
  // The word is extended with an implicit 1 below comp[0] and an implicit 0
  // above comp[M-1]. Each position takes the majority of itself and its two
  // neighbours, and the result is the number of ones after correction.
  function automatic logic [NBITS-1:0] therm_to_code(input logic [M-1:0] t);
    logic [M+1:0]     te;
    logic [NBITS-1:0] n;
    te = {1'b0, t, 1'b1};
    n  = {NBITS{1'b0}};
    for (int i = 0; i < M; i++) begin
      n = n + NBITS'(maj3(te[i], te[i+1], te[i+2]));
    end
    return n;
  endfunction

  // A raw word is not a valid thermometer if a comparator reads 1 while the
  // comparator directly below it reads 0.
  function automatic logic therm_invalid(input logic [M-1:0] t);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < M - 1; i++) begin
      bad = bad | (t[i+1] & ~t[i]);
    end
    return bad;
  endfunction

  state_t             state_r;
  logic [PH_W-1:0]    phase_r;
  logic [CNT_W-1:0]   conv_r;
  logic [ACC_W-1:0]   acc_r;
  logic               bub_acc_r;
  logic               samp_r;
  logic               busy_r;
  logic [NBITS-1:0]   dout_r;
  logic               dout_valid_r;
  logic               eoc_r;
  logic               bubble_err_r;

  logic [NBITS-1:0]   code_s;
  logic               raw_bad_s;
  logic [ACC_W-1:0]   sum_s;

  // Decode the live comparator word and form the running sum.
  // These values are consumed only in the CAPTURE state.
  always_comb begin
    code_s    = therm_to_code(comp);
    raw_bad_s = therm_invalid(comp);
    sum_s     = acc_r + ACC_W'(code_s);
  end

  // Sequencer FSM with accumulator and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r      <= ST_IDLE;
      phase_r      <= {PH_W{1'b0}};
      conv_r       <= {CNT_W{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      bub_acc_r    <= 1'b0;
      samp_r       <= 1'b0;
      busy_r       <= 1'b0;
      dout_r       <= {NBITS{1'b0}};
      dout_valid_r <= 1'b0;
      eoc_r        <= 1'b0;
      bubble_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          eoc_r <= 1'b0;
          if (start) begin
            state_r   <= ST_SAMPLE;
            phase_r   <= {PH_W{1'b0}};
            conv_r    <= {CNT_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            bub_acc_r <= 1'b0;
            samp_r    <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            busy_r <= 1'b0;
            samp_r <= 1'b0;
          end
        end

        ST_SAMPLE: begin
          if (phase_r == SAMP_LAST) begin
            state_r <= ST_SETTLE;
            phase_r <= {PH_W{1'b0}};
            samp_r  <= 1'b0;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end

        ST_SETTLE: begin
          if (phase_r == SETTLE_LAST) begin
            state_r <= ST_CAPTURE;
            phase_r <= {PH_W{1'b0}};
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end

        ST_CAPTURE: begin
          // comp is looked at only in this cycle.
          acc_r     <= sum_s;
          bub_acc_r <= bub_acc_r | raw_bad_s;
          if (conv_r == LAST_CONV) begin
            // The last capture goes straight into the result register.
            // Truncating the average is intended.
            state_r      <= ST_RESULT;
            dout_r       <= NBITS'(sum_s >> AVG_LOG2);
            bubble_err_r <= bub_acc_r | raw_bad_s;
            dout_valid_r <= 1'b1;
            eoc_r        <= 1'b1;
          end else begin
            state_r <= ST_SAMPLE;
            conv_r  <= conv_r + CNT_W'(1);
            samp_r  <= 1'b1;
          end
        end

        ST_RESULT: begin
          eoc_r <= 1'b0;
          // dout and bubble_err stay frozen until the consumer takes them.
          // A start that arrives here is dropped.
          if (dout_ready) begin
            state_r      <= ST_IDLE;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
          end else begin
            dout_valid_r <= 1'b1;
          end
        end

        default: begin
          state_r      <= ST_IDLE;
          samp_r       <= 1'b0;
          busy_r       <= 1'b0;
          dout_valid_r <= 1'b0;
          eoc_r        <= 1'b0;
        end
      endcase
    end
  end

  assign samp       = samp_r;
  assign busy       = busy_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign eoc        = eoc_r;
  assign bubble_err = bubble_err_r;

endmodule
